// File: rtl/dmx_pkg.sv
// Shared definitions for the DMX512 frame scheduler: FSM state encoding,
// universe size, default 4 MHz phase lengths and the slot-count clamp.
package dmx_pkg;

  localparam int DMX_MAX_SLOTS   = 512;
  localparam int SLOT_W          = 10;
  localparam int DEF_BREAK_TICKS = 352;    // 88 us at 4 MHz
  localparam int DEF_MAB_TICKS   = 48;     // 12 us at 4 MHz
  localparam int DEF_FRAME_TICKS = 92000;  // 23 ms at 4 MHz

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BREAK,
    ST_MAB,
    ST_START,
    ST_FETCH,
    ST_WAIT_RD,
    ST_SEND,
    ST_IFT
  } dmx_state_e;

  // A universe never carries more than 512 slots.
  function automatic logic [SLOT_W-1:0] clamp_slots(input logic [SLOT_W-1:0] n);
    return (n > SLOT_W'(DMX_MAX_SLOTS)) ? SLOT_W'(DMX_MAX_SLOTS) : n;
  endfunction

endpackage

// File: rtl/dmx_tick_timer.sv
// Loadable down-counter used for the BREAK and MAB phase lengths.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : load load_val_i this cycle (takes priority over counting)
//   load_val_i    : phase length minus one
//   done_o        : counter has reached zero (last cycle of the phase)
module dmx_tick_timer #(
  parameter int W = 17
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = load_val_i;
    else if (cnt_q != '0)    cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/dmx_frame_scheduler.sv
// DMX512 frame sequencer: BREAK, MAB, start code, slot bytes fetched from the
// channel RAM, then MARK until the minimum break-to-break period has elapsed.
//   dmxclk, rst_n          : clock, asynchronous active-low reset
//   enable                 : run frames; sampled only at frame boundaries
//   slot_count, start_code : frame config, latched at each BREAK entry
//   rd_en/rd_addr/rd_data  : channel RAM read port (data one cycle after rd_en)
//   tx_data/tx_valid/tx_ready : byte handshake to the serializer
//   line_break             : force line low
//   busy, frame_done       : status; frame_done pulses on last-byte accept
module dmx_frame_scheduler
  import dmx_pkg::*;
#(
  parameter int BREAK_TICKS = DEF_BREAK_TICKS,
  parameter int MAB_TICKS   = DEF_MAB_TICKS,
  parameter int FRAME_TICKS = DEF_FRAME_TICKS,
  parameter int ADDR_W      = 9,
  parameter int TMR_W       = 17
) (
  input  logic              dmxclk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [9:0]        slot_count,
  input  logic [7:0]        start_code,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              line_break,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(FRAME_TICKS - 1);

  dmx_state_e         state_q, state_d;
  logic [SLOT_W-1:0]  slots_q, slots_d;
  logic [7:0]         sc_q, sc_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [TMR_W-1:0]   per_q, per_d;

  logic               ph_load;
  logic [TMR_W-1:0]   ph_val;
  logic               ph_done;
  logic               start_frame;
  logic               fdone;
  logic               per_exp;
  logic               last_slot;

  assign per_exp   = (per_q == PER_LAST);
  assign last_slot = (SLOT_W'(addr_q) == slots_q - SLOT_W'(1));

  dmx_tick_timer #(.W(TMR_W)) u_phase (
    .clk_i      (dmxclk),
    .rst_ni     (rst_n),
    .load_i     (ph_load),
    .load_val_i (ph_val),
    .done_o     (ph_done)
  );

  always_comb begin
    state_d     = state_q;
    slots_d     = slots_q;
    sc_d        = sc_q;
    tx_data_d   = tx_data_q;
    addr_d      = addr_q;
    ph_load     = 1'b0;
    ph_val      = TMR_W'(MAB_TICKS - 1);
    start_frame = 1'b0;
    fdone       = 1'b0;

    case (state_q)
      ST_IDLE:  if (enable) start_frame = 1'b1;
      ST_BREAK: if (ph_done) begin
        state_d = ST_MAB;
        ph_load = 1'b1;
      end
      ST_MAB: if (ph_done) begin
        state_d   = ST_START;
        tx_data_d = sc_q;
      end
      ST_START: if (tx_ready) begin
        if (slots_q == '0) begin
          fdone   = 1'b1;
          state_d = ST_IFT;
        end else begin
          addr_d  = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH:   state_d = ST_WAIT_RD;
      ST_WAIT_RD: begin
        tx_data_d = rd_data;
        state_d   = ST_SEND;
      end
      ST_SEND: if (tx_ready) begin
        if (last_slot) begin
          fdone   = 1'b1;
          state_d = ST_IFT;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_IFT: if (per_exp) begin
        if (enable) start_frame = 1'b1;
        else        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Entering BREAK re-latches config so mid-frame changes never leak in.
    if (start_frame) begin
      state_d = ST_BREAK;
      slots_d = clamp_slots(slot_count);
      sc_d    = start_code;
      addr_d  = '0;
      ph_load = 1'b1;
      ph_val  = TMR_W'(BREAK_TICKS - 1);
    end
  end

  // Period timer reads 0 on the first BREAK cycle and saturates, so an
  // overlong frame leaves IFT after a single cycle.
  always_comb begin
    per_d = per_q;
    if (start_frame)   per_d = '0;
    else if (!per_exp) per_d = per_q + TMR_W'(1);
  end

  always_ff @(posedge dmxclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      slots_q   <= '0;
      sc_q      <= '0;
      tx_data_q <= '0;
      addr_q    <= '0;
      per_q     <= '0;
    end else begin
      state_q   <= state_d;
      slots_q   <= slots_d;
      sc_q      <= sc_d;
      tx_data_q <= tx_data_d;
      addr_q    <= addr_d;
      per_q     <= per_d;
    end
  end

  assign rd_en      = (state_q == ST_FETCH);
  assign rd_addr    = addr_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = (state_q == ST_START) || (state_q == ST_SEND);
  assign line_break = (state_q == ST_BREAK);
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = fdone;

endmodule

// File: tb/tb_dmx_frame_scheduler.sv
module tb_dmx_frame_scheduler;

  localparam int FRAME = 1500;
  localparam int BRK   = 352;
  localparam int MAB   = 48;

  logic       dmxclk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [9:0] slot_count;
  logic [7:0] start_code;
  logic       rd_en;
  logic [8:0] rd_addr;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       line_break;
  logic       busy;
  logic       frame_done;

  dmx_frame_scheduler #(
    .BREAK_TICKS(BRK), .MAB_TICKS(MAB), .FRAME_TICKS(FRAME), .ADDR_W(9), .TMR_W(17)
  ) dut (
    .dmxclk(dmxclk), .rst_n(rst_n), .enable(enable), .slot_count(slot_count),
    .start_code(start_code), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .line_break(line_break), .busy(busy), .frame_done(frame_done)
  );

  always #5 dmxclk = ~dmxclk;

  // Channel RAM: data valid only in the cycle after rd_en, garbage otherwise.
  logic [7:0] ram [512];
  always @(posedge dmxclk) begin
    if (rd_en) rd_data <= ram[rd_addr];
    else       rd_data <= 8'hA5;
  end

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] sb[$];

  int cyc = 0, brk_cnt = 0, brk_start = 0, prev_brk_start = 0, brk_len = 0;
  int lb_fall = 0, mab_len = 0, rd_cnt = 0, last_rd_addr = -1, fd_cnt = 0, fd_cyc = 0;
  int min_gap = 0, max_gap = 0;

  typedef struct {
    logic [9:0] cnt;
    logic [7:0] code;
    int         nslots;
    int         last_addr;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge dmxclk); #1;
  endtask

  task automatic monitor();
    logic prev_lb = 0, prev_vld = 0, prev_acc = 0, mab_pend = 0, acc_first = 1;
    logic [7:0] prev_data = 0;
    int last_acc = 0;
    forever begin
      @(negedge dmxclk);
      cyc++;
      if (!rst_n) begin
        prev_lb = 0; prev_vld = 0; prev_acc = 0; mab_pend = 0;
      end else begin
        if (line_break && !prev_lb) begin
          prev_brk_start = brk_start; brk_start = cyc; brk_cnt++;
          acc_first = 1; min_gap = 1 << 30; max_gap = 0;
        end
        if (!line_break && prev_lb) begin
          brk_len = cyc - brk_start; lb_fall = cyc; mab_pend = 1;
        end
        if (tx_valid && mab_pend) begin
          mab_len = cyc - lb_fall; mab_pend = 0;
        end
        if (prev_vld && !prev_acc) begin
          chk("hold_valid", int'(tx_valid), 1);
          chk("hold_data", int'(tx_data), int'(prev_data));
        end
        if (rd_en) begin rd_cnt++; last_rd_addr = int'(rd_addr); end
        if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
        if (tx_valid && tx_ready) begin
          if (!acc_first) begin
            if (cyc - last_acc < min_gap) min_gap = cyc - last_acc;
            if (cyc - last_acc > max_gap) max_gap = cyc - last_acc;
          end
          acc_first = 0; last_acc = cyc;
          if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL sb_underflow: byte 0x%0h accepted, none expected", tx_data);
          end else begin
            chk("byte", int'(tx_data), int'(sb.pop_front()));
          end
        end
        prev_lb = line_break; prev_vld = tx_valid;
        prev_acc = tx_valid && tx_ready; prev_data = tx_data;
      end
    end
  endtask

  task automatic wait_fd(input int target, input int bound);
    for (int i = 0; i < bound && fd_cnt < target; i++) cyc1();
    chk("wait_frame_done", fd_cnt, target);
  endtask

  task automatic wait_brk(input int target, input int bound);
    for (int i = 0; i < bound && brk_cnt < target; i++) cyc1();
    chk("wait_break", brk_cnt, target);
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && busy; i++) cyc1();
    chk("wait_idle", int'(busy), 0);
  endtask

  // Returns in the FETCH cycle for the given slot address.
  task automatic wait_fetch(input int addr, input int bound);
    int found = 0;
    for (int i = 0; i < bound && found == 0; i++) begin
      cyc1();
      if (rd_en && int'(rd_addr) == addr) found = 1;
    end
    chk("wait_fetch", found, 1);
  endtask

  task automatic push_frame(input logic [7:0] code, input int n);
    sb.push_back(code);
    for (int i = 0; i < n; i++) sb.push_back(ram[i]);
  endtask

  task automatic run_frame(input vec_t v);
    int fd0 = fd_cnt, rd0 = rd_cnt, brk0 = brk_cnt;
    slot_count = v.cnt; start_code = v.code;
    push_frame(v.code, v.nslots);
    enable = 1;
    wait_fd(fd0 + 1, BRK + MAB + 4 * v.nslots + 200);
    enable = 0;
    wait_idle(3000);
    chk("break_len", brk_len, BRK);
    chk("mab_len", mab_len, MAB);
    chk("break_count", brk_cnt - brk0, 1);
    chk("frame_done_count", fd_cnt - fd0, 1);
    chk("rd_count", rd_cnt - rd0, v.nslots);
    chk("sb_empty", sb.size(), 0);
    if (v.nslots > 0) begin
      chk("last_rd_addr", last_rd_addr, v.last_addr);
      chk("min_gap", min_gap, 3);
      chk("max_gap", max_gap, 3);
    end
  endtask

  initial begin
    int fd0, rd0, brk0, good;
    for (int i = 0; i < 512; i++) ram[i] = 8'((i + 1) * 17);
    rst_n = 0; enable = 0; slot_count = 0; start_code = 0; tx_ready = 1;
    fork monitor(); join_none

    vecs[0] = '{10'd3,   8'h00, 3,   2};
    vecs[1] = '{10'd0,   8'h5A, 0,   0};
    vecs[2] = '{10'd1,   8'hC3, 1,   0};
    vecs[3] = '{10'd7,   8'h17, 7,   6};
    vecs[4] = '{10'd513, 8'hAA, 512, 511};

    repeat (3) cyc1();
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_tx_valid", int'(tx_valid), 0);
    chk("rst_line_break", int'(line_break), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    rst_n = 1;
    cyc1();

    foreach (vecs[i]) run_frame(vecs[i]);

    // Back-pressure on slot 1: byte held stable, no RAM reads while stalled.
    slot_count = 3; start_code = 8'h00;
    push_frame(8'h00, 3);
    fd0 = fd_cnt; enable = 1;
    wait_fetch(1, 1000);
    tx_ready = 0;
    cyc1(); cyc1();
    rd0 = rd_cnt; good = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx_valid && tx_data == 8'h22) good++;
      cyc1();
    end
    chk("stall_stable", good, 100);
    chk("stall_no_rd", rd_cnt - rd0, 0);
    tx_ready = 1;
    wait_fd(fd0 + 1, 200);
    enable = 0;
    wait_idle(3000);
    chk("stall_sb_empty", sb.size(), 0);

    // Zero slots: break-to-break spacing is exactly the frame period.
    slot_count = 0; start_code = 8'h55;
    push_frame(8'h55, 0); push_frame(8'h55, 0);
    fd0 = fd_cnt; rd0 = rd_cnt; brk0 = brk_cnt; enable = 1;
    wait_brk(brk0 + 2, 2 * FRAME + 100);
    enable = 0;
    chk("period", brk_start - prev_brk_start, FRAME);
    wait_idle(3000);
    chk("zero_fd", fd_cnt - fd0, 2);
    chk("zero_rd", rd_cnt - rd0, 0);
    chk("zero_sb_empty", sb.size(), 0);

    // Clamp to 512 slots; overlong frame rebreaks right after IFT entry.
    slot_count = 10'd600; start_code = 8'h00;
    push_frame(8'h00, 512);
    fd0 = fd_cnt; rd0 = rd_cnt; brk0 = brk_cnt; enable = 1;
    wait_fd(fd0 + 1, 3000);
    chk("clamp_rd_count", rd_cnt - rd0, 512);
    chk("clamp_last_addr", last_rd_addr, 511);
    wait_brk(brk0 + 2, 10);
    chk("ift_one_cycle", brk_start - fd_cyc, 2);
    enable = 0;
    push_frame(8'h00, 512);
    wait_idle(3000);
    chk("clamp_sb_empty", sb.size(), 0);

    // Enable dropped and config changed mid-frame: frame finishes as latched.
    slot_count = 10; start_code = 8'h10;
    push_frame(8'h10, 10);
    fd0 = fd_cnt; rd0 = rd_cnt; enable = 1;
    wait_fetch(5, 1000);
    enable = 0; slot_count = 2; start_code = 8'hEE;
    wait_idle(3000);
    chk("drop_fd", fd_cnt - fd0, 1);
    chk("drop_rd", rd_cnt - rd0, 10);
    chk("drop_last_addr", last_rd_addr, 9);
    chk("drop_sb_empty", sb.size(), 0);
    brk0 = brk_cnt;
    repeat (2000) cyc1();
    chk("drop_no_break", brk_cnt - brk0, 0);
    chk("drop_busy", int'(busy), 0);

    // Reset while a byte is stalled in SEND.
    slot_count = 10; start_code = 8'h33;
    push_frame(8'h33, 10);
    enable = 1;
    wait_fetch(2, 1000);
    tx_ready = 0;
    cyc1(); cyc1();
    chk("pre_rst_valid", int'(tx_valid), 1);
    rst_n = 0;
    #1;
    chk("rst_mid_tx_valid", int'(tx_valid), 0);
    chk("rst_mid_line_break", int'(line_break), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_rd_en", int'(rd_en), 0);
    sb.delete();
    cyc1();
    rst_n = 1; tx_ready = 1;
    push_frame(8'h33, 10);
    fd0 = fd_cnt; brk0 = brk_cnt;
    wait_fd(fd0 + 1, 1000);
    enable = 0;
    wait_idle(3000);
    chk("post_rst_break", brk_cnt - brk0, 1);
    chk("post_rst_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
